// File: rtl/seg_msg_if.sv
// Bus between the glyph sequencer and its surroundings: control levels in,
// ROM address out / glyph in, display bus and status out.
//   start/stop/step/loop_en/blank_en/dwell : control levels into the sequencer
//   rom_addr / rom_data                    : external combinational glyph ROM
//   seg_out / busy / done                  : display bus and status
interface seg_msg_if #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               step;
  logic               loop_en;
  logic               blank_en;
  logic [DWELL_W-1:0] dwell;
  logic [ADDR_W-1:0]  rom_addr;
  logic [7:0]         rom_data;
  logic [7:0]         seg_out;
  logic               busy;
  logic               done;

  // Controller / ROM side
  modport master (
    output start, stop, step, loop_en, blank_en, dwell, rom_data,
    input  rom_addr, seg_out, busy, done
  );

  // Sequencer side
  modport slave (
    input  start, stop, step, loop_en, blank_en, dwell, rom_data,
    output rom_addr, seg_out, busy, done
  );
endinterface

// File: rtl/seg_msg_sequencer.sv
// Walks a 7-segment glyph ROM onto the display bus with per-glyph dwell,
// optional blank gap, and run/stop/step/one-shot control.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : seg_msg_if slave (controls, ROM address/data, seg_out, busy, done)
module seg_msg_sequencer #(
  parameter int unsigned MSG_LEN = 14,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DWELL_W = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  seg_msg_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHOW,
    S_GAP,
    S_HOLD,
    S_HLOAD
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr;
  logic [DWELL_W-1:0] cnt;
  logic [7:0]         seg;
  logic               done_q;
  logic [ADDR_W-1:0]  addr_next;

  // Message address always wraps; loop_en only decides whether SHOW exits to IDLE
  assign addr_next = (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);

  // Sequencer FSM; stop has priority over every transition out of the active states
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      addr   <= '0;
      cnt    <= '0;
      seg    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.stop) state <= S_LOAD;
        end
        S_LOAD: begin
          // stop here freezes the previous glyph on the bus
          if (bus.stop) begin
            state <= S_HOLD;
          end else begin
            seg   <= bus.rom_data;
            cnt   <= bus.dwell;
            state <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (bus.stop) begin
            state <= S_HOLD;
          end else if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else if ((addr == LAST_ADDR) && !bus.loop_en) begin
            state  <= S_IDLE;
            addr   <= '0;
            seg    <= '0;
            done_q <= 1'b1;
          end else if (bus.blank_en) begin
            state <= S_GAP;
            addr  <= addr_next;
            seg   <= '0;
            cnt   <= bus.dwell;
          end else begin
            // previous glyph stays visible through the LOAD cycle
            state <= S_LOAD;
            addr  <= addr_next;
          end
        end
        S_GAP: begin
          if (bus.stop) begin
            state <= S_HOLD;
          end else if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else begin
            state <= S_LOAD;
          end
        end
        S_HOLD: begin
          if (!bus.stop) begin
            if (bus.start) begin
              state <= S_LOAD;
            end else if (bus.step) begin
              addr  <= addr_next;
              state <= S_HLOAD;
            end
          end
        end
        S_HLOAD: begin
          seg   <= bus.rom_data;
          state <= S_HOLD;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rom_addr = addr;
  assign bus.seg_out  = seg;
  assign bus.done     = done_q;
  assign bus.busy     = (state != S_IDLE);

endmodule

// File: tb/tb_seg_msg_sequencer.sv
// Directed bench for seg_msg_sequencer: glyph sequence scoreboard plus
// cycle-exact checks of timing, hold/step control, one-shot done and reset.
module tb_seg_msg_sequencer;

  localparam int unsigned MSG_LEN = 14;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned DWELL_W = 8;

  logic clk = 1'b0;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] last_seg;

  seg_msg_if #(.ADDR_W(ADDR_W), .DWELL_W(DWELL_W)) bif ();

  seg_msg_sequencer #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W), .DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  // Glyph ROM: distinct non-zero byte per address so blanks are unambiguous
  function automatic logic [7:0] glyph(input int a);
    return 8'(a * 29 + 65);
  endfunction

  assign bif.rom_data = glyph(int'(bif.rom_addr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; every new non-blank glyph on the bus is matched against the queue
  task automatic cyc();
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (bif.seg_out !== last_seg) begin
      if (bif.seg_out !== 8'h00) begin
        e = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'h100;
        chk("sb_glyph", 32'(bif.seg_out), e);
      end
      last_seg = bif.seg_out;
    end
  endtask

  task automatic wait_seg(input logic [7:0] target, input string tag);
    int n;
    n = 0;
    while (bif.seg_out !== target && n < 200) begin
      cyc();
      n++;
    end
    chk(tag, 32'(bif.seg_out), 32'(target));
  endtask

  initial begin
    rst_n        = 1'b0;
    bif.start    = 1'b0;
    bif.stop     = 1'b0;
    bif.step     = 1'b0;
    bif.loop_en  = 1'b0;
    bif.blank_en = 1'b0;
    bif.dwell    = '0;
    last_seg     = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seg", 32'(bif.seg_out), 32'h0);
    chk("rst_addr", 32'(bif.rom_addr), 32'h0);
    chk("rst_busy", 32'(bif.busy), 32'h0);
    chk("rst_done", 32'(bif.done), 32'h0);
    rst_n = 1'b1;
    cyc();
    chk("idle_busy", 32'(bif.busy), 32'h0);

    // T1: continuous loop, dwell=0, glyph every 2 cycles
    bif.loop_en = 1'b1;
    bif.dwell   = 8'd0;
    for (int k = 0; k < 14; k++) exp_q.push_back(glyph(k));
    exp_q.push_back(glyph(0));
    bif.start = 1'b1;
    cyc();
    chk("t1_busy_load", 32'(bif.busy), 32'h1);
    chk("t1_seg_load", 32'(bif.seg_out), 32'h0);
    cyc();
    chk("t1_first", 32'(bif.seg_out), 32'(glyph(0)));
    for (int k = 1; k <= 14; k++) begin
      cyc();
      chk("t1_hold_old", 32'(bif.seg_out), 32'(glyph(k - 1)));
      chk("t1_addr", 32'(bif.rom_addr), 32'(k % 14));
      cyc();
      chk("t1_glyph", 32'(bif.seg_out), 32'(glyph(k % 14)));
      chk("t1_busy", 32'(bif.busy), 32'h1);
    end
    chk("t1_sb_drained", 32'(exp_q.size()), 32'h0);

    // T2: one-shot, dwell=3, done pulse then restart
    bif.loop_en = 1'b0;
    bif.dwell   = 8'd3;
    for (int k = 1; k < 14; k++) exp_q.push_back(glyph(k));
    wait_seg(glyph(13), "t2_reach13");
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_show13", 32'(bif.seg_out), 32'(glyph(13)));
      chk("t2_no_done", 32'(bif.done), 32'h0);
      chk("t2_busy", 32'(bif.busy), 32'h1);
    end
    exp_q.push_back(glyph(0));
    cyc();
    chk("t2_end_seg", 32'(bif.seg_out), 32'h0);
    chk("t2_done", 32'(bif.done), 32'h1);
    chk("t2_idle", 32'(bif.busy), 32'h0);
    chk("t2_addr0", 32'(bif.rom_addr), 32'h0);
    cyc();
    chk("t2_done_pulse", 32'(bif.done), 32'h0);
    chk("t2_restart_busy", 32'(bif.busy), 32'h1);
    cyc();
    chk("t2_restart_g0", 32'(bif.seg_out), 32'(glyph(0)));
    chk("t2_sb_drained", 32'(exp_q.size()), 32'h0);

    // T3: blank gap, dwell=2: 3 cycles on, 4 cycles off
    bif.dwell    = 8'd2;
    bif.blank_en = 1'b1;
    bif.loop_en  = 1'b1;
    for (int k = 1; k <= 4; k++) exp_q.push_back(glyph(k));
    wait_seg(glyph(1), "t3_reach1");
    for (int k = 1; k <= 3; k++) begin
      repeat (2) begin
        cyc();
        chk("t3_on", 32'(bif.seg_out), 32'(glyph(k)));
      end
      cyc();
      chk("t3_gap_start", 32'(bif.seg_out), 32'h0);
      chk("t3_addr", 32'(bif.rom_addr), 32'(k + 1));
      repeat (3) begin
        cyc();
        chk("t3_off", 32'(bif.seg_out), 32'h0);
      end
      cyc();
      chk("t3_next", 32'(bif.seg_out), 32'(glyph(k + 1)));
    end

    // T4: stop on final SHOW cycle of glyph5, step x3, resume
    bif.blank_en = 1'b0;
    exp_q.push_back(glyph(5));
    wait_seg(glyph(5), "t4_reach5");
    repeat (2) cyc();
    bif.stop = 1'b1;
    cyc();
    chk("t4_hold_addr", 32'(bif.rom_addr), 32'h5);
    chk("t4_hold_seg", 32'(bif.seg_out), 32'(glyph(5)));
    chk("t4_hold_busy", 32'(bif.busy), 32'h1);
    bif.stop  = 1'b0;
    bif.start = 1'b0;
    cyc();
    chk("t4_still_5", 32'(bif.rom_addr), 32'h5);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(glyph(6 + i));
      bif.step = 1'b1;
      cyc();
      chk("t4_step_addr", 32'(bif.rom_addr), 32'(6 + i));
      bif.step = 1'b0;
      cyc();
      chk("t4_step_seg", 32'(bif.seg_out), 32'(glyph(6 + i)));
      cyc();
      chk("t4_step_stable", 32'(bif.rom_addr), 32'(6 + i));
    end
    exp_q.push_back(glyph(9));
    bif.start = 1'b1;
    cyc();
    bif.start = 1'b0;
    chk("t4_resume_addr", 32'(bif.rom_addr), 32'h8);
    repeat (3) begin
      cyc();
      chk("t4_reshow", 32'(bif.seg_out), 32'(glyph(8)));
      chk("t4_reshow_addr", 32'(bif.rom_addr), 32'h8);
    end
    cyc();
    chk("t4_adv_addr", 32'(bif.rom_addr), 32'h9);
    cyc();
    chk("t4_adv_seg", 32'(bif.seg_out), 32'(glyph(9)));

    // T5: step wraps 13->0 with loop_en=0, no done; start&stop keeps HOLD
    bif.stop = 1'b1;
    cyc();
    bif.stop = 1'b0;
    for (int a = 10; a <= 13; a++) begin
      exp_q.push_back(glyph(a));
      bif.step = 1'b1;
      cyc();
      bif.step = 1'b0;
      cyc();
      chk("t5_step_seg", 32'(bif.seg_out), 32'(glyph(a)));
    end
    bif.loop_en = 1'b0;
    exp_q.push_back(glyph(0));
    bif.step = 1'b1;
    cyc();
    chk("t5_wrap_addr", 32'(bif.rom_addr), 32'h0);
    chk("t5_wrap_done", 32'(bif.done), 32'h0);
    bif.step = 1'b0;
    cyc();
    chk("t5_wrap_seg", 32'(bif.seg_out), 32'(glyph(0)));
    chk("t5_wrap_done2", 32'(bif.done), 32'h0);
    bif.start = 1'b1;
    bif.stop  = 1'b1;
    repeat (6) cyc();
    chk("t5_ss_addr", 32'(bif.rom_addr), 32'h0);
    chk("t5_ss_seg", 32'(bif.seg_out), 32'(glyph(0)));
    chk("t5_ss_busy", 32'(bif.busy), 32'h1);

    // T6: asynchronous reset mid-SHOW at addr 9
    bif.stop    = 1'b0;
    bif.loop_en = 1'b1;
    for (int k = 1; k <= 9; k++) exp_q.push_back(glyph(k));
    wait_seg(glyph(9), "t6_reach9");
    bif.start = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    chk("t6_async_seg", 32'(bif.seg_out), 32'h0);
    chk("t6_async_addr", 32'(bif.rom_addr), 32'h0);
    chk("t6_async_busy", 32'(bif.busy), 32'h0);
    cyc();
    rst_n = 1'b1;
    repeat (5) begin
      cyc();
      chk("t6_idle_busy", 32'(bif.busy), 32'h0);
      chk("t6_idle_seg", 32'(bif.seg_out), 32'h0);
      chk("t6_idle_addr", 32'(bif.rom_addr), 32'h0);
    end
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
